// File: rtl/led_event_scheduler.sv
// led_event_scheduler
// Shares a single front-panel LED between several asynchronous event inputs.
// Every rising edge on an input is queued. A round-robin scheduler then shows
// each queued event as one stretched LED pulse followed by a dark gap.
// Events that arrive while their source is already queued are dropped and
// flagged in a sticky overrun register.
module led_event_scheduler #(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int NUM_SOURCES   = 4,
    parameter int ON_MS         = 100,
    parameter int GAP_MS        = 50,
    localparam int IW           = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   rst_a,
    input  logic [NUM_SOURCES-1:0] event_a,
    input  logic                   clearOverrun,
    output logic                   led,
    output logic [IW-1:0]          activeIndex,
    output logic                   active,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [NUM_SOURCES-1:0] overrun
);

    // Pulse and gap lengths in clock ticks.
    localparam int ON_TICKS  = $rtoi(real'(CLK_FREQUENCY) / 1.0e3 * real'(ON_MS));
    localparam int GAP_TICKS = $rtoi(real'(CLK_FREQUENCY) / 1.0e3 * real'(GAP_MS));
    localparam int MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] GAP_LOAD = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Registered rising-edge pulses, one per source.
    logic [NUM_SOURCES-1:0] rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            (* ASYNC_REG = "TRUE" *) logic meta_q;
            (* ASYNC_REG = "TRUE" *) logic sync_q;
            logic sync_dly_q;
            logic rise_q;

            // Two-flop synchronizer, delayed copy and registered edge detect.
            // Registers reset low, so an input already high at reset release
            // produces one rising edge.
            always_ff @(posedge clk or posedge rst_a) begin
                if (rst_a) begin
                    meta_q     <= 1'b0;
                    sync_q     <= 1'b0;
                    sync_dly_q <= 1'b0;
                    rise_q     <= 1'b0;
                end else begin
                    meta_q     <= event_a[gi];
                    sync_q     <= meta_q;
                    sync_dly_q <= sync_q;
                    rise_q     <= sync_q & ~sync_dly_q;
                end
            end

            assign rise[gi] = rise_q;
        end
    endgenerate

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   led_q, led_d;
    logic                   active_q, active_d;
    logic [IW-1:0]          index_q, index_d;
    logic [IW-1:0]          last_grant_q, last_grant_d;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] overrun_q, overrun_d;

    logic                   grant_valid;
    logic [IW-1:0]          grant_idx;
    logic [NUM_SOURCES-1:0] grant_vec;

    // Round-robin search: first pending source after the last one granted,
    // wrapping from NUM_SOURCES-1 back to 0.
    always_comb begin
        int          pos;
        logic [IW-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            pos  = (int'(last_grant_q) + k) % NUM_SOURCES;
            cand = IW'(pos);
            if (!grant_valid && pending_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot grant, only when the FSM actually takes the event.
    always_comb begin
        grant_vec = '0;
        if (state_q == S_IDLE && grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Queue and overrun bookkeeping. A new rise on the same cycle as the grant
    // re-queues the source instead of counting as an overrun; a new overrun
    // beats a simultaneous clear.
    always_comb begin
        pending_d = (pending_q & ~grant_vec) | rise;
        overrun_d = (overrun_q & ~{NUM_SOURCES{clearOverrun}})
                  | (rise & pending_q & ~grant_vec);
    end

    // Pulse sequencer: IDLE -> ON (led lit) -> GAP (dark, still active) -> IDLE.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        led_d        = led_q;
        active_d     = active_q;
        index_d      = index_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    led_d        = 1'b1;
                    active_d     = 1'b1;
                    index_d      = grant_idx;
                    last_grant_d = grant_idx;
                    count_d      = ON_LOAD;
                    state_d      = S_ON;
                end
            end
            S_ON: begin
                if (count_q == '0) begin
                    led_d = 1'b0;
                    if (GAP_TICKS > 0) begin
                        count_d = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        active_d = 1'b0;
                        index_d  = '0;
                        state_d  = S_IDLE;
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            S_GAP: begin
                if (count_q == '0) begin
                    active_d = 1'b0;
                    index_d  = '0;
                    state_d  = S_IDLE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: begin
                led_d    = 1'b0;
                active_d = 1'b0;
                index_d  = '0;
                count_d  = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State registers; reset mid-pulse darkens the LED immediately.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            led_q        <= 1'b0;
            active_q     <= 1'b0;
            index_q      <= '0;
            last_grant_q <= IW'(NUM_SOURCES - 1);
            pending_q    <= '0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            led_q        <= led_d;
            active_q     <= active_d;
            index_q      <= index_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
        end
    end

    assign led         = led_q;
    assign active      = active_q;
    assign activeIndex = index_q;
    assign pending     = pending_q;
    assign overrun     = overrun_q;

endmodule
